// File: rtl/line_err_calc.sv
// Weighted left-minus-right line-position error from eight IR readings, one shared adder, 8 accumulate cycles.
// Optional LOST_SEEK_EN: while the line is lost, error is driven to full scale toward the side it was last seen.
module line_err_calc #(
  parameter int SHIFT       = 4,
  parameter int LOST_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IR_vld,
  input  logic        line_present,
  input  logic [11:0] IR_L0,
  input  logic [11:0] IR_L1,
  input  logic [11:0] IR_L2,
  input  logic [11:0] IR_L3,
  input  logic [11:0] IR_R0,
  input  logic [11:0] IR_R1,
  input  logic [11:0] IR_R2,
  input  logic [11:0] IR_R3,
  output logic [11:0] error,
  output logic        err_vld,
  output logic        line_lost,
  output logic        ovr
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  localparam logic [3:0] LOST_TH = 4'(LOST_FRAMES);

  state_e             state_q;
  logic signed [17:0] acc_q;
  logic        [2:0]  idx_q;
  logic        [3:0]  lost_cnt_q;
  logic        [11:0] error_q;
  logic               err_vld_q;
  logic               line_lost_q;
  logic               ovr_q;
  logic        [11:0] l_q [4];
  logic        [11:0] r_q [4];
`ifdef LOST_SEEK_EN
  logic               last_neg_q;
`endif

  logic        [11:0] sel;
  logic signed [17:0] term;
  logic signed [17:0] acc_d;
  logic signed [17:0] shifted;
  logic        [11:0] err_sat;
  logic        [3:0]  lost_cnt_d;
  logic               accept;

  assign accept = (state_q == IDLE) && IR_vld && line_present;

  // Even idx selects L[idx/2] (added), odd idx selects R[idx/2] (subtracted); weight 2^(idx/2).
  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    sel        = idx_q[0] ? r_q[idx_q[2:1]] : l_q[idx_q[2:1]];
    term       = 18'(sel) << idx_q[2:1];
    acc_d      = idx_q[0] ? (acc_q - term) : (acc_q + term);
    shifted    = acc_q >>> SHIFT;
    err_sat    = shifted[11:0];
    if (shifted > 18'sd2047) begin
      err_sat = 12'h7FF;
    end else if (shifted < -18'sd2048) begin
      err_sat = 12'h800;
    end
    lost_cnt_d = (lost_cnt_q == 4'd15) ? lost_cnt_q : lost_cnt_q + 4'd1;
  end

  // NOTE: the reading buffer is pure datapath, always written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      l_q <= '{IR_L0, IR_L1, IR_L2, IR_L3};
      r_q <= '{IR_R0, IR_R1, IR_R2, IR_R3};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      lost_cnt_q  <= '0;
      error_q     <= '0;
      err_vld_q   <= 1'b0;
      line_lost_q <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef LOST_SEEK_EN
      last_neg_q  <= 1'b0;
`endif
    end else begin
      err_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (IR_vld) begin
            if (line_present) begin
              acc_q       <= '0;
              idx_q       <= '0;
              lost_cnt_q  <= '0;
              line_lost_q <= 1'b0;
              state_q     <= ACCUM;
            end else begin
              lost_cnt_q  <= lost_cnt_d;
              line_lost_q <= (lost_cnt_d >= LOST_TH);
              err_vld_q   <= 1'b1;
`ifdef LOST_SEEK_EN
              if (lost_cnt_d >= LOST_TH) begin
                error_q <= last_neg_q ? 12'h800 : 12'h7FF;
              end
`endif
            end
          end
        end
        ACCUM: begin
          ovr_q <= IR_vld;
          acc_q <= acc_d;
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          ovr_q     <= IR_vld;
          error_q   <= err_sat;
          err_vld_q <= 1'b1;
`ifdef LOST_SEEK_EN
          last_neg_q <= err_sat[11];
`endif
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign error     = error_q;
  assign err_vld   = err_vld_q;
  assign line_lost = line_lost_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_line_err_calc.sv
// Randomized self-checking bench for line_err_calc against an arithmetic reference model.
module tb_line_err_calc;

  localparam int SHIFT = 4;
  localparam int LF    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IR_vld = 1'b0;
  logic        line_present = 1'b0;
  logic [11:0] IR_L0 = '0, IR_L1 = '0, IR_L2 = '0, IR_L3 = '0;
  logic [11:0] IR_R0 = '0, IR_R1 = '0, IR_R2 = '0, IR_R3 = '0;
  logic [11:0] error;
  logic        err_vld, line_lost, ovr;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int m_err      = 0;
  int m_cnt      = 0;
  bit m_lost     = 1'b0;
  bit m_last_neg = 1'b0;

  always #5 clk = ~clk;

  line_err_calc #(.SHIFT(SHIFT), .LOST_FRAMES(LF)) dut (
    .clk(clk), .rst_n(rst_n), .IR_vld(IR_vld), .line_present(line_present),
    .IR_L0(IR_L0), .IR_L1(IR_L1), .IR_L2(IR_L2), .IR_L3(IR_L3),
    .IR_R0(IR_R0), .IR_R1(IR_R1), .IR_R2(IR_R2), .IR_R3(IR_R3),
    .error(error), .err_vld(err_vld), .line_lost(line_lost), .ovr(ovr)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [11:0] rand12();
    case ($urandom % 4)
      0:       return 12'h000;
      1:       return 12'hFFF;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic drive(input logic [3:0][11:0] l, input logic [3:0][11:0] r, input bit lp);
    IR_L0 = l[0]; IR_L1 = l[1]; IR_L2 = l[2]; IR_L3 = l[3];
    IR_R0 = r[0]; IR_R1 = r[1]; IR_R2 = r[2]; IR_R3 = r[3];
    line_present = lp;
  endtask

  // Position error from plain integer arithmetic: sum (L_i - R_i) * 2^i, floor shift, clamp.
  function automatic void model(input logic [3:0][11:0] l, input logic [3:0][11:0] r, input bit lp);
    int sum;
    sum = 0;
    if (lp) begin
      for (int i = 0; i < 4; i++) sum += (int'(l[i]) - int'(r[i])) * (1 << i);
      sum = sum >>> SHIFT;
      if (sum > 2047)  sum = 2047;
      if (sum < -2048) sum = -2048;
      m_err      = sum & 'hFFF;
      m_last_neg = (sum < 0);
      m_cnt      = 0;
      m_lost     = 1'b0;
    end else begin
      if (m_cnt < 15) m_cnt++;
      m_lost = (m_cnt >= LF);
`ifdef LOST_SEEK_EN
      if (m_lost) m_err = m_last_neg ? 'h800 : 'h7FF;
`endif
    end
  endfunction

  // One frame: drive it, optionally inject a colliding IR_vld ovr_at cycles later, check the result.
  task automatic frame(input logic [3:0][11:0] l, input logic [3:0][11:0] r, input bit lp,
                       input int ovr_at, input string tag);
    int lat = 0, ovr_cnt = 0, unstable = 0;
    logic [11:0] prev;
    logic [3:0][11:0] jl, jr;
    @(negedge clk);
    prev = error;
    drive(l, r, lp);
    IR_vld = 1'b1;
    model(l, r, lp);
    for (int i = 1; i <= 25 && lat == 0; i++) begin
      @(negedge clk);
      if (ovr) ovr_cnt++;
      if (err_vld) lat = i;
      else if (error !== prev) unstable++;
      IR_vld = 1'b0;
      if (i == ovr_at) begin
        for (int k = 0; k < 4; k++) begin jl[k] = rand12(); jr[k] = rand12(); end
        drive(jl, jr, 1'($urandom % 2));
        IR_vld = 1'b1;
      end
    end
    check({tag, "_lat"}, lat, lp ? 10 : 1);
    check({tag, "_err"}, int'(error), m_err);
    check({tag, "_lost"}, int'(line_lost), int'(m_lost));
    check({tag, "_stable"}, unstable, 0);
    @(negedge clk);
    if (ovr) ovr_cnt++;
    check({tag, "_vld_pulse"}, int'(err_vld), 0);
    check({tag, "_ovr"}, ovr_cnt, (ovr_at > 0) ? 1 : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][11:0] L, R;
    int vld_cnt;

    repeat (3) @(negedge clk);
    check("rst_error", int'(error), 0);
    check("rst_err_vld", int'(err_vld), 0);
    check("rst_line_lost", int'(line_lost), 0);
    check("rst_ovr", int'(ovr), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    L = {4{12'h100}}; R = '0;
    frame(L, R, 1'b1, 0, "inner_outer");
    L = '0; L[3] = 12'hFFF; R = '0;
    frame(L, R, 1'b1, 0, "l3_full");
    L = '0; R = '0; R[2] = 12'hFFF; R[3] = 12'hFFF;
    frame(L, R, 1'b1, 0, "neg_sat");
    L = {4{12'h5A5}}; R = {4{12'h5A5}};
    frame(L, R, 1'b1, 0, "symmetric");

    // Line lost: three frames raise line_lost, more frames check the counter saturates rather than wraps.
    L = {4{12'h100}}; R = '0;
    frame(L, R, 1'b1, 0, "pre_lost");
    for (int i = 0; i < 17; i++) frame(L, R, 1'b0, 0, $sformatf("lost%0d", i));
    L = {4{12'h123}}; R = {4{12'h045}};
    frame(L, R, 1'b1, 0, "found");

    L = {4{12'h100}}; R = '0;
    frame(L, R, 1'b1, 4, "overrun");

    // Reset in the 5th ACCUM cycle.
    L = {4{12'h0F0}}; R = '0;
    @(negedge clk);
    drive(L, R, 1'b1);
    IR_vld = 1'b1;
    @(negedge clk);
    IR_vld = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_error", int'(error), 0);
    check("midrst_err_vld", int'(err_vld), 0);
    check("midrst_line_lost", int'(line_lost), 0);
    check("midrst_ovr", int'(ovr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_err = 0; m_cnt = 0; m_lost = 1'b0; m_last_neg = 1'b0;
    vld_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (err_vld) vld_cnt++;
    end
    check("midrst_no_vld", vld_cnt, 0);
    L = {4{12'h200}}; R = {4{12'h080}};
    frame(L, R, 1'b1, 0, "after_rst");

    // Randomized frames: mixed line-present / lost, occasional collisions.
    for (int n = 0; n < 40; n++) begin
      bit lp;
      for (int k = 0; k < 4; k++) begin L[k] = rand12(); R[k] = rand12(); end
      lp = ($urandom % 4) != 0;
      frame(L, R, lp, (lp && ($urandom % 3 == 0)) ? $urandom_range(1, 9) : 0, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/line_err_calc.md
Name: line_err_calc

Overview:
Downstream consumer of IR_intf. It captures the eight 12-bit IR sensor readings on each IR_vld pulse. It then computes a signed, weighted left-minus-right line-position error over 8 cycles using a single shared adder. The result feeds the steering PID as error plus an err_vld strobe. It also tracks consecutive frames with no line and raises line_lost.

Parameters:
SHIFT, 4, arithmetic right shift applied to the raw 18-bit difference before saturation to 12 bits
LOST_FRAMES, 3, number of consecutive IR_vld frames with line_present=0 before line_lost asserts (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
IR_vld  in  1  one-cycle pulse from IR_intf; all IR_* and line_present are valid in that cycle
line_present  in  1  line detected flag, sampled only when IR_vld=1
IR_L0..IR_L3  in  12 each  left sensors, L0 innermost, L3 outermost
IR_R0..IR_R3  in  12 each  right sensors, R0 innermost, R3 outermost
error  out  12  signed saturated position error; positive means the line is to the left
err_vld  out  1  one-cycle pulse when error has been updated
line_lost  out  1  level; high while the lost count is at or above LOST_FRAMES
ovr  out  1  one-cycle pulse when IR_vld arrives while busy (that frame is dropped)

Behaviour:
- Reset values: error=0, err_vld=0, line_lost=0, ovr=0. Internal state: lost_cnt=0, acc=0, idx=0, state=IDLE.
- Weights: index i (0..3) has weight 2^i, so inner=1 and outer=8, implemented as shifts. Left terms add; right terms subtract.
- Accumulator: 18-bit signed; the maximum magnitude of 4095*15=61425 cannot overflow.
- State IDLE:
  - On IR_vld=1 with line_present=1: latch all 8 readings, clear acc, set idx=0, clear lost_cnt and line_lost, go to ACCUM.
  - On IR_vld=1 with line_present=0: no latch; lost_cnt increments, saturating at 15. line_lost becomes 1 on the same edge that lost_cnt reaches LOST_FRAMES. error is unchanged (see Optional Feature). err_vld pulses the next cycle. Stay in IDLE.
- State ACCUM: one term per cycle, 8 cycles, order L0,R0,L1,R1,L2,R2,L3,R3. After idx=7, go to DONE.
- State DONE:
  - Compute shifted = acc >>> SHIFT (arithmetic, floor).
  - Saturate to 12-bit signed: >2047 becomes 0x7FF, <-2048 becomes 0x800.
  - Register into error and pulse err_vld for one cycle. Return to IDLE.
- Latency: IR_vld at edge N (line present) produces err_vld high in cycle N+10. The unit is busy for 10 cycles.
- IR_vld while in ACCUM or DONE: the frame is ignored, latched values are untouched, ovr pulses for one cycle, and lost_cnt is unaffected.
- Registers stay stable between updates; error changes only in the cycle err_vld is asserted.
- Asynchronous reset mid-ACCUM: the computation is abandoned, all outputs return to reset values, and no err_vld is produced for the interrupted frame.

Optional Feature:
Macro LOST_SEEK_EN.
- Defined: while line_lost=1, every lost-frame err_vld drives error to 0x7FF if the last valid computed error was >=0, otherwise 0x800. This makes the PID steer hard toward the side the line was last seen. The next line-present frame restores normal computation.
- Undefined: error holds its last valid computed value while lost. err_vld still pulses on each lost frame.

Test Plan:
- Reset, then IR_vld with all L=0x100, all R=0, line_present=1 -> err_vld exactly 10 cycles later, error=0x0F0 (3840>>>4=240), line_lost=0.
- L3=0xFFF, all others 0 -> error=0x7FF (32760>>>4=2047, no saturation needed); then R2=R3=0xFFF, others 0 -> raw -49140>>>4=-3072 saturates to error=0x800.
- Symmetric input L_i=R_i=0x5A5 for all i -> error=0x000.
- After a frame giving error=0x0F0, three IR_vld with line_present=0 (LOST_FRAMES=3) -> line_lost rises on the 3rd frame and three err_vld pulses occur. Without LOST_SEEK_EN error stays 0x0F0; with it error=0x7FF. A following line-present frame clears line_lost.
- IR_vld pulses again 4 cycles after the first -> ovr pulses once, and the result matches the first frame only.
- Assert rst_n=0 in the 5th ACCUM cycle -> error=0, err_vld never pulses; a new frame afterwards computes correctly.
